dram_ctrl: RTL and testbench

DRAM_CTRL -- requirements
Module: dram_ctrl

---
 rtl/dram_ctrl_if.sv | 18 +
 rtl/dram_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dram_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dram_ctrl_if.sv
// CPU-side bus bundle for dram_ctrl: 68040 transfer request in, DRAM strobes and TA out.
interface dram_ctrl_if;
   logic        TS_n;
   logic        SEL;
   logic [21:0] A;
   logic [1:0]  SIZ;
   logic        RW;
   logic        TA_n;
   logic        RAS_n;
   logic [3:0]  CAS_n;
   logic        WE_n;
   logic [9:0]  MA;

   modport master (output TS_n, SEL, A, SIZ, RW,
                   input  TA_n, RAS_n, CAS_n, WE_n, MA);
   modport slave  (input  TS_n, SEL, A, SIZ, RW,
                   output TA_n, RAS_n, CAS_n, WE_n, MA);
endinterface

// File: rtl/dram_ctrl.sv
// 68040 DRAM controller: RAS/CAS sequencing, 4-beat wrapping line bursts, CBR refresh.
// Refresh hardware is built only when DRAM_CTRL_REFRESH_EN is defined.
module dram_ctrl #(
   parameter int REFRESH_DIV = 495,
   parameter int PRECHARGE   = 2
) (
   input  logic        BCLK,
   input  logic        RESET,
   dram_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, ROW, CAS, CASHI, PRE, REFC, REFR} state_t;
   localparam int CW = $clog2(PRECHARGE + 2);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_beat;
   logic          r_pend;
   logic [21:0]   r_p_a;
   logic [1:0]    r_p_siz;
   logic          r_p_rw;
   logic [11:0]   r_c_a;
   logic [1:0]    r_c_siz;
   logic          r_ta_n, r_ras_n, r_we_n;
   logic [3:0]    r_cas_n;
   logic [9:0]    r_ma;

   logic          w_ts, w_req, w_dispatch, w_ref_pend, w_rw;
   logic [21:0]   w_a;
   logic [1:0]    w_siz;

   assign w_ts       = !bus.TS_n && bus.SEL;
   assign w_req      = r_pend || w_ts;
   assign w_a        = r_pend ? r_p_a   : bus.A;
   assign w_siz      = r_pend ? r_p_siz : bus.SIZ;
   assign w_rw       = r_pend ? r_p_rw  : bus.RW;
   assign w_dispatch = (r_state == IDLE) || (r_state == PRE && r_cnt == '0);

`ifdef DRAM_CTRL_REFRESH_EN
   localparam int RCW = $clog2(REFRESH_DIV + 1);
   logic [RCW-1:0] r_ref_cnt;
   logic           r_ref_pend;
   logic           w_wrap, w_ref_take;

   // A wrap on a dispatch edge is taken immediately, so refresh beats a same-edge TS.
   assign w_wrap     = (r_ref_cnt == RCW'(REFRESH_DIV - 1));
   assign w_ref_pend = r_ref_pend || w_wrap;
   assign w_ref_take = w_dispatch && w_ref_pend;

   always_ff @(posedge BCLK) begin
      if (RESET) begin
         r_ref_cnt  <= '0;
         r_ref_pend <= 1'b0;
      end else begin
         r_ref_cnt <= w_wrap ? '0 : r_ref_cnt + 1'b1;
         if (w_ref_take)  r_ref_pend <= 1'b0;
         else if (w_wrap) r_ref_pend <= 1'b1;
      end
   end
`else
   assign w_ref_pend = 1'b0;
`endif

   // Active-low lane enables; bit 3 carries byte offset 0.
   function automatic logic [3:0] cas_lanes(input logic [1:0] siz, input logic [1:0] a);
      case (siz)
         2'b01:   cas_lanes = ~(4'b1000 >> a);
         2'b10:   cas_lanes = a[1] ? 4'b1100 : 4'b0011;
         default: cas_lanes = 4'b0000;
      endcase
   endfunction

   always_ff @(posedge BCLK) begin
      if (RESET) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_beat  <= 2'd0;
         r_pend  <= 1'b0;
         r_p_a   <= '0;
         r_p_siz <= 2'b00;
         r_p_rw  <= 1'b1;
         r_c_a   <= '0;
         r_c_siz <= 2'b00;
         r_ta_n  <= 1'b1;
         r_ras_n <= 1'b1;
         r_cas_n <= 4'hF;
         r_we_n  <= 1'b1;
         r_ma    <= '0;
      end else begin
         if (w_ts && !r_pend) begin
            r_pend  <= 1'b1;
            r_p_a   <= bus.A;
            r_p_siz <= bus.SIZ;
            r_p_rw  <= bus.RW;
         end
         // IDLE and the last PRE clock share one dispatch so back-to-back accesses skip IDLE.
         if (w_dispatch) begin
            if (w_ref_pend) begin
               r_state <= REFC;
               r_cas_n <= 4'h0;
               r_ras_n <= 1'b1;
               r_we_n  <= 1'b1;
               r_ta_n  <= 1'b1;
            end else if (w_req) begin
               r_state <= ROW;
               r_ras_n <= 1'b0;
               r_we_n  <= w_rw;
               r_ma    <= w_a[21:12];
               r_c_a   <= w_a[11:0];
               r_c_siz <= w_siz;
               r_beat  <= 2'd0;
               r_pend  <= 1'b0;
            end else begin
               r_state <= IDLE;
            end
         end else begin
            case (r_state)
               ROW, CASHI: begin
                  r_state <= CAS;
                  r_ma    <= {r_c_a[11:4], r_c_a[3:2] + r_beat};
                  r_cas_n <= cas_lanes(r_c_siz, r_c_a[1:0]);
                  r_ta_n  <= 1'b0;
               end
               CAS: begin
                  r_cas_n <= 4'hF;
                  r_ta_n  <= 1'b1;
                  if (r_c_siz == 2'b11 && r_beat != 2'd3) begin
                     r_state <= CASHI;
                     r_beat  <= r_beat + 2'd1;
                  end else begin
                     r_state <= PRE;
                     r_ras_n <= 1'b1;
                     r_we_n  <= 1'b1;
                     r_cnt   <= CW'(PRECHARGE - 1);
                  end
               end
               PRE: r_cnt <= r_cnt - 1'b1;
               REFC: begin
                  r_state <= REFR;
                  r_ras_n <= 1'b0;
                  r_cnt   <= CW'(1);
               end
               REFR: begin
                  if (r_cnt == '0) begin
                     r_state <= PRE;
                     r_ras_n <= 1'b1;
                     r_cas_n <= 4'hF;
                     r_cnt   <= CW'(PRECHARGE - 1);
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.TA_n  = r_ta_n;
   assign bus.RAS_n = r_ras_n;
   assign bus.CAS_n = r_cas_n;
   assign bus.WE_n  = r_we_n;
   assign bus.MA    = r_ma;
endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: schedules transfers, predicts the strobe timeline per access, compares per edge.
// Refresh-priority scenario runs when DRAM_CTRL_REFRESH_EN is defined; otherwise directed + random accesses.
module tb_dram_ctrl;
   localparam int PRE_C = 2;
`ifdef DRAM_CTRL_REFRESH_EN
   localparam int RDIV  = 8;
`else
   localparam int RDIV  = 495;
`endif
   localparam int MAXE  = 4096;

   logic BCLK = 1'b0;
   logic RESET;
   dram_ctrl_if bus();

   dram_ctrl #(.REFRESH_DIV(RDIV), .PRECHARGE(PRE_C)) dut (
      .BCLK  (BCLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 BCLK = ~BCLK;

   // stimulus schedule, observed trace and predicted trace, all indexed by edge
   logic        s_ts[MAXE], s_rw[MAXE], s_rst[MAXE];
   logic [21:0] s_a[MAXE];
   logic [1:0]  s_siz[MAXE];
   logic        o_ta[MAXE], o_ras[MAXE], o_we[MAXE];
   logic [3:0]  o_cas[MAXE];
   logic [9:0]  o_ma[MAXE];
   logic        e_ta[MAXE], e_ras[MAXE], e_we[MAXE], e_mav[MAXE];
   logic [3:0]  e_cas[MAXE];
   logic [9:0]  e_ma[MAXE];

   int n_chk = 0;
   int n_fail = 0;
   int free_e = 0;

   task automatic chk(input string tag, input int e, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %h expected %h", tag, e, got, exp);
      end
   endtask

   // Access timeline from the bus rules: dispatch when the controller is free, row
   // strobe from dispatch, one TA every other clock, then PRE_C precharge clocks.
   task automatic add_tx(input int t, input logic [21:0] a, input logic [1:0] siz,
                         input logic rw, output int dsp);
      int d, beats, nb, st;
      logic [3:0] m;
      logic [1:0] c;
      s_ts[t] = 1'b1; s_a[t] = a; s_siz[t] = siz; s_rw[t] = rw;
      d     = (t > free_e) ? t : free_e;
      beats = (siz == 2'b11) ? 4 : 1;
      nb    = (siz == 2'b01) ? 1 : (siz == 2'b10) ? 2 : 4;
      st    = (siz == 2'b01) ? int'(a[1:0]) : (siz == 2'b10) ? (a[1] ? 2 : 0) : 0;
      m = 4'hF;
      for (int b = st; b < st + nb; b++) m[3-b] = 1'b0;
      for (int e = d; e < d + 2*beats; e++) begin
         e_ras[e] = 1'b0;
         e_we[e]  = rw;
      end
      e_mav[d] = 1'b1;
      e_ma[d]  = a[21:12];
      for (int k = 0; k < beats; k++) begin
         c = a[3:2] + 2'(k);
         e_ta[d+1+2*k]  = 1'b0;
         e_cas[d+1+2*k] = m;
         e_mav[d+1+2*k] = 1'b1;
         e_ma[d+1+2*k]  = {a[11:4], c};
      end
      free_e = d + 2*beats + PRE_C;
      dsp = d;
   endtask

   task automatic run(input int n);
      for (int e = 0; e < n; e++) begin
         @(negedge BCLK);
         RESET = s_rst[e];
         if (s_ts[e]) begin
            bus.TS_n = 1'b0; bus.SEL = 1'b1;
            bus.A = s_a[e]; bus.SIZ = s_siz[e]; bus.RW = s_rw[e];
         end else begin
            // noise: TS_n low with SEL low must not start anything
            bus.SEL  = 1'($urandom);
            bus.TS_n = bus.SEL ? 1'b1 : 1'($urandom);
            bus.A    = 22'($urandom);
            bus.SIZ  = 2'($urandom);
            bus.RW   = 1'($urandom);
         end
         @(posedge BCLK);
         #1;
         o_ta[e] = bus.TA_n; o_ras[e] = bus.RAS_n; o_cas[e] = bus.CAS_n;
         o_we[e] = bus.WE_n; o_ma[e]  = bus.MA;
      end
   endtask

   initial begin
      int d, hi, n_edges;
      for (int e = 0; e < MAXE; e++) begin
         s_ts[e] = 1'b0; s_a[e] = '0; s_siz[e] = 2'b00; s_rw[e] = 1'b1; s_rst[e] = (e < 3);
         e_ta[e] = 1'b1; e_ras[e] = 1'b1; e_we[e] = 1'b1; e_mav[e] = 1'b0;
         e_cas[e] = 4'hF; e_ma[e] = '0;
      end
      RESET = 1'b1; bus.TS_n = 1'b1; bus.SEL = 1'b0; bus.A = '0; bus.SIZ = 2'b00; bus.RW = 1'b1;
`ifdef DRAM_CTRL_REFRESH_EN
      // counter wraps at edge 10; TS on that edge waits behind REFC, REFR x2, PRE x2
      free_e = 15;
      add_tx(10, 22'h2A5F30, 2'b00, 1'b1, d);
      e_cas[10] = 4'h0;
      e_ras[11] = 1'b0; e_cas[11] = 4'h0;
      e_ras[12] = 1'b0; e_cas[12] = 4'h0;
      hi = 17; n_edges = 20;
      run(n_edges);
`else
      begin
         int t, gap, lows;
         add_tx(5, 22'h000000, 2'b11, 1'b1, d);
         add_tx(free_e + 2, 22'h00100C, 2'b11, 1'b1, d);
         add_tx(free_e + 1, 22'h000002, 2'b01, 1'b0, d);
         add_tx(free_e, 22'h2C4406, 2'b10, 1'b0, d);
         add_tx(free_e + 3, 22'h3FF004, 2'b00, 1'b0, d);
         // next TS lands mid-access; a further TS while it is pending is dropped
         t = d + 1;
         add_tx(t, 22'h155AA8, 2'b10, 1'b1, d);
         s_ts[t+1] = 1'b1; s_a[t+1] = 22'h0ABCDE; s_siz[t+1] = 2'b01; s_rw[t+1] = 1'b0;
         for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(1, free_e - d + 4);
            add_tx(d + gap, 22'($urandom), 2'($urandom), 1'($urandom), d);
         end
         // reset on the edge after the second TA of a line read
         add_tx(free_e + 3, 22'($urandom), 2'b11, 1'b1, d);
         s_rst[d+5] = 1'b1;
         for (int e = d + 5; e < d + 30; e++) begin
            e_ras[e] = 1'b1; e_ta[e] = 1'b1; e_cas[e] = 4'hF; e_we[e] = 1'b1;
            e_mav[e] = 1'b1; e_ma[e] = '0;
         end
         hi = d + 29; n_edges = d + 30 + 2000;
         run(n_edges);
         lows = 0;
         for (int e = hi + 1; e < n_edges; e++) if (o_ras[e] !== 1'b1) lows++;
         chk("ras_idle_lows", hi + 1, 32'(lows), 32'd0);
      end
`endif
      chk("rst_ta",  2, 32'(o_ta[2]),  32'd1);
      chk("rst_ras", 2, 32'(o_ras[2]), 32'd1);
      chk("rst_cas", 2, 32'(o_cas[2]), 32'hF);
      chk("rst_we",  2, 32'(o_we[2]),  32'd1);
      chk("rst_ma",  2, 32'(o_ma[2]),  32'd0);
      for (int e = 3; e <= hi; e++) begin
         chk("ras", e, 32'(o_ras[e]), 32'(e_ras[e]));
         chk("ta",  e, 32'(o_ta[e]),  32'(e_ta[e]));
         chk("cas", e, 32'(o_cas[e]), 32'(e_cas[e]));
         chk("we",  e, 32'(o_we[e]),  32'(e_we[e]));
         if (e_mav[e]) chk("ma", e, 32'(o_ma[e]), 32'(e_ma[e]));
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
